// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-port arbiter sharing one 4-bit add/subtract unit; define ADDSUB_ARB_OVF_EN to add o_rsp_ovf

module addr_subtr (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_control_signal,
  output logic [3:0] o_result,
  output logic       o_carry
);
  logic [4:0] w_sum;

  // Subtract is a + ~b + 1; carry out doubles as "no borrow" for subtract
  assign w_sum    = {1'b0, i_a} + {1'b0, i_b ^ {4{i_control_signal}}} + {4'b0000, i_control_signal};
  assign o_result = w_sum[3:0];
  assign o_carry  = w_sum[4];
endmodule

module addsub_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0_valid,
  input  logic [3:0] i_req0_a,
  input  logic [3:0] i_req0_b,
  input  logic       i_req0_sub,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [3:0] i_req1_a,
  input  logic [3:0] i_req1_b,
  input  logic       i_req1_sub,
  output logic       o_req1_ready,
  output logic       o_rsp0_valid,
  input  logic       i_rsp0_ready,
  output logic       o_rsp1_valid,
  input  logic       i_rsp1_ready,
  output logic [3:0] o_rsp_result,
  output logic       o_rsp_carry,
  output logic       o_busy
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic       o_rsp_ovf
`endif
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_last;
  logic       r_owner;
  logic       r_sub;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_result;
  logic       r_carry;
  logic       w_any_valid;
  logic       w_grant;
  logic       w_accept;
  logic       w_rsp_done;
  logic [3:0] w_unit_result;
  logic       w_unit_carry;

  assign w_any_valid  = i_req0_valid | i_req1_valid;
  assign o_rsp_result = r_result;
  assign o_rsp_carry  = r_carry;

  addr_subtr u_addr_subtr (
    .i_a              (r_a),
    .i_b              (r_b),
    .i_control_signal (r_sub),
    .o_result         (w_unit_result),
    .o_carry          (w_unit_carry)
  );

  // Pick the winner: lone requester, else port 0 (fixed) or the port not served last
  always_comb begin
    w_grant = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grant = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    end else if (i_req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rsp0_valid = 1'b0;
    o_rsp1_valid = 1'b0;
    o_busy       = 1'b0;
    w_accept     = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_rst && w_any_valid) begin
          o_req0_ready = ~w_grant;
          o_req1_ready = w_grant;
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        o_busy       = 1'b1;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        o_busy       = 1'b1;
        o_rsp0_valid = ~r_owner;
        o_rsp1_valid = r_owner;
        w_rsp_done   = r_owner ? i_rsp1_ready : i_rsp0_ready;
        if (w_rsp_done) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture, result registration and last-served pointer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= 4'd0;
      r_b      <= 4'd0;
      r_sub    <= 1'b0;
      r_owner  <= 1'b0;
      r_result <= 4'd0;
      r_carry  <= 1'b0;
      r_last   <= 1'b1;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant;
        r_a     <= w_grant ? i_req1_a   : i_req0_a;
        r_b     <= w_grant ? i_req1_b   : i_req0_b;
        r_sub   <= w_grant ? i_req1_sub : i_req0_sub;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_unit_result;
        r_carry  <= w_unit_carry;
      end
      if (w_rsp_done) begin
        r_last <= r_owner;
      end
    end
  end

`ifdef ADDSUB_ARB_OVF_EN
  logic r_ovf;
  logic w_unit_ovf;

  assign w_unit_ovf = (r_a[3] == (r_b[3] ^ r_sub)) && (w_unit_result[3] != r_a[3]);
  assign o_rsp_ovf  = r_ovf;

  // Signed overflow flag registered alongside the result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_ovf <= w_unit_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - self-checking bench for addsub_arbiter (round-robin and fixed-priority instances)

module tb_addsub_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, s0, s1, rr0, rr1;
  logic [3:0] a0, b0, a1, b1;
  logic       r0, r1, q0, q1, cy, busy, ovf;
  logic [3:0] res;
  logic       fp_r0, fp_r1, fp_q0, fp_q1, fp_cy, fp_busy, fp_ovf;
  logic [3:0] fp_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.FIXED_PRIO(0)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_sub(s0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_sub(s1), .o_req1_ready(r1),
    .o_rsp0_valid(q0), .i_rsp0_ready(rr0), .o_rsp1_valid(q1), .i_rsp1_ready(rr1),
    .o_rsp_result(res), .o_rsp_carry(cy), .o_busy(busy)
`ifdef ADDSUB_ARB_OVF_EN
    , .o_rsp_ovf(ovf)
`endif
  );

  addsub_arbiter #(.FIXED_PRIO(1)) u_dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_sub(s0), .o_req0_ready(fp_r0),
    .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_sub(s1), .o_req1_ready(fp_r1),
    .o_rsp0_valid(fp_q0), .i_rsp0_ready(rr0), .o_rsp1_valid(fp_q1), .i_rsp1_ready(rr1),
    .o_rsp_result(fp_res), .o_rsp_carry(fp_cy), .o_busy(fp_busy)
`ifdef ADDSUB_ARB_OVF_EN
    , .o_rsp_ovf(fp_ovf)
`endif
  );

`ifndef ADDSUB_ARB_OVF_EN
  assign ovf    = 1'b0;
  assign fp_ovf = 1'b0;
`endif

  typedef struct {
    int port;
    int a;
    int b;
    int sub;
    int res;
    int carry;
    int ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference arithmetic from plain integer rules: {ovf, carry, result}
  function automatic logic [5:0] model(input int a, input int b, input int sub);
    int r, c, o, sa, sb, sr;
    if (sub != 0) begin
      r = (a - b + 16) % 16;
      c = (a >= b) ? 1 : 0;
    end else begin
      r = (a + b) % 16;
      c = ((a + b) >= 16) ? 1 : 0;
    end
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    sr = (sub != 0) ? sa - sb : sa + sb;
    o  = (sr > 7 || sr < -8) ? 1 : 0;
    return 6'(o * 32 + c * 16 + r);
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int n;
    @(posedge clk);
    #1;
    rr0 = 1'b1; rr1 = 1'b1;
    if (v.port == 0) begin
      v0 = 1'b1; v1 = 1'b0; a0 = 4'(v.a); b0 = 4'(v.b); s0 = 1'(v.sub);
    end else begin
      v1 = 1'b1; v0 = 1'b0; a1 = 4'(v.a); b1 = 4'(v.b); s1 = 1'(v.sub);
    end
    n = 0;
    @(negedge clk);
    while (((v.port == 0) ? r0 : r1) != 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("vec%0d_ready", idx), (v.port == 0) ? int'(r0) : int'(r1), 1);
    @(posedge clk);
    #1 v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_exec_rsp_valid", idx), int'(q0 | q1), 0);
    chk($sformatf("vec%0d_exec_busy", idx), int'(busy), 1);
    @(negedge clk);
    chk($sformatf("vec%0d_rsp0_valid", idx), int'(q0), (v.port == 0) ? 1 : 0);
    chk($sformatf("vec%0d_rsp1_valid", idx), int'(q1), (v.port == 1) ? 1 : 0);
    chk($sformatf("vec%0d_result", idx), int'(res), v.res);
    chk($sformatf("vec%0d_carry", idx), int'(cy), v.carry);
`ifdef ADDSUB_ARB_OVF_EN
    chk($sformatf("vec%0d_ovf", idx), int'(ovf), v.ovf);
`endif
    @(negedge clk);
    chk($sformatf("vec%0d_idle_busy", idx), int'(busy), 0);
  endtask

  initial begin
    int acc_cyc[$], acc_port[$], fp_cyc[$], fp_port[$];
    int pend[2], pa[2], pb[2], ps[2];
    int m_out, m_owner, m_age, m_last, acc_flag, acc_port_r, done_flag, w;
    logic [5:0] m_exp;

    vecs[0] = '{0, 9, 8, 0, 1, 1, 1};
    vecs[1] = '{0, 5, 3, 1, 2, 1, 0};
    vecs[2] = '{1, 3, 5, 1, 14, 0, 0};
    vecs[3] = '{0, 7, 1, 0, 8, 0, 1};
    vecs[4] = '{1, 8, 1, 1, 7, 1, 1};
    vecs[5] = '{0, 2, 3, 0, 5, 0, 0};
    vecs[6] = '{1, 15, 15, 0, 14, 1, 0};
    vecs[7] = '{0, 0, 0, 1, 0, 1, 0};
    vecs[8] = '{1, 0, 1, 1, 15, 0, 0};

    // Reset with both requests pending
    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
    a0 = 4'd1; b0 = 4'd1; s0 = 1'b0; a1 = 4'd2; b1 = 4'd2; s1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready0", int'(r0), 0);
      chk("rst_ready1", int'(r1), 0);
      chk("rst_rsp_valid", int'(q0 | q1), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_result", int'(res), 0);
      chk("rst_carry", int'(cy), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_tie_ready0", int'(r0), 1);
    chk("first_tie_ready1", int'(r1), 0);
    v0 = 1'b0; v1 = 1'b0;

    // Table-driven single operations
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i], i);
    end

    // Continuous contention: round-robin alternates, fixed priority keeps port 0
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    a0 = 4'd1; b0 = 4'd2; s0 = 1'b0; a1 = 4'd6; b1 = 4'd4; s1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rr_onehot", int'(r0 & r1), 0);
      if (r0 | r1) begin
        acc_cyc.push_back(c);
        acc_port.push_back(r1 ? 1 : 0);
      end
      if (fp_r0 | fp_r1) begin
        fp_cyc.push_back(c);
        fp_port.push_back(fp_r1 ? 1 : 0);
      end
    end
    chk("rr_count", acc_cyc.size(), 4);
    for (int i = 0; i < acc_cyc.size(); i++) begin
      chk($sformatf("rr_cycle%0d", i), acc_cyc[i], 3 * i);
      chk($sformatf("rr_port%0d", i), acc_port[i], i % 2);
    end
    chk("fp_count", fp_cyc.size(), 4);
    for (int i = 0; i < fp_cyc.size(); i++) begin
      chk($sformatf("fp_cycle%0d", i), fp_cyc[i], 3 * i);
      chk($sformatf("fp_port%0d", i), fp_port[i], 0);
    end

    // Response backpressure on port 1, then reset while in RESP
    reset_dut();
    @(posedge clk);
    #1;
    rr0 = 1'b1; rr1 = 1'b0;
    v1 = 1'b1; a1 = 4'd3; b1 = 4'd5; s1 = 1'b1;
    @(negedge clk);
    chk("bp_ready1", int'(r1), 1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v0 = 1'b1; a0 = 4'd4; b0 = 4'd4; s0 = 1'b0;
    @(negedge clk);
    chk("bp_exec_ready0", int'(r0), 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp1_valid", int'(q1), 1);
      chk("bp_rsp0_valid", int'(q0), 0);
      chk("bp_result", int'(res), 14);
      chk("bp_carry", int'(cy), 0);
      chk("bp_ready0", int'(r0), 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready0", int'(r0), 0);
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rsp1_valid", int'(q1), 0);
    chk("midrst_result", int'(res), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_ready0", int'(r0), 1);
    v0 = 1'b0;

    // Randomized traffic against the scoreboard model
    reset_dut();
    pend = '{0, 0};
    m_out = 0; m_owner = 0; m_age = 0; m_last = 1;
    acc_flag = 0; acc_port_r = 0; done_flag = 0; m_exp = 6'd0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk);
      if (m_out != 0) m_age++;
      if (done_flag != 0) begin
        m_out  = 0;
        m_last = m_owner;
      end
      if (acc_flag != 0) begin
        pend[acc_port_r] = 0;
        m_out   = 1;
        m_owner = acc_port_r;
        m_age   = 1;
        m_exp   = model(pa[acc_port_r], pb[acc_port_r], ps[acc_port_r]);
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] == 0 && $urandom_range(0, 1) == 1) begin
          pend[p] = 1;
          pa[p] = $urandom_range(0, 15);
          pb[p] = $urandom_range(0, 15);
          ps[p] = $urandom_range(0, 1);
        end
      end
      v0 = 1'(pend[0]); a0 = 4'(pa[0]); b0 = 4'(pb[0]); s0 = 1'(ps[0]);
      v1 = 1'(pend[1]); a1 = 4'(pa[1]); b1 = 4'(pb[1]); s1 = 1'(ps[1]);
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_flag = 0;
      done_flag = 0;
      if (m_out == 0) begin
        if (pend[0] != 0 && pend[1] != 0) w = 1 - m_last;
        else w = (pend[1] != 0) ? 1 : 0;
        chk("rnd_ready0", int'(r0), (pend[0] != 0 && w == 0) ? 1 : 0);
        chk("rnd_ready1", int'(r1), (pend[1] != 0 && w == 1) ? 1 : 0);
        chk("rnd_idle_busy", int'(busy), 0);
        chk("rnd_idle_rsp_valid", int'(q0 | q1), 0);
        if (pend[w] != 0) begin
          acc_flag = 1;
          acc_port_r = w;
        end
      end else begin
        chk("rnd_busy_ready", int'(r0 | r1), 0);
        chk("rnd_busy", int'(busy), 1);
        if (m_age == 1) begin
          chk("rnd_exec_rsp_valid", int'(q0 | q1), 0);
        end else begin
          chk("rnd_rsp0_valid", int'(q0), (m_owner == 0) ? 1 : 0);
          chk("rnd_rsp1_valid", int'(q1), (m_owner == 1) ? 1 : 0);
          chk("rnd_result", int'(res), int'(m_exp[3:0]));
          chk("rnd_carry", int'(cy), int'(m_exp[4]));
`ifdef ADDSUB_ARB_OVF_EN
          chk("rnd_ovf", int'(ovf), int'(m_exp[5]));
`endif
          done_flag = (m_owner == 1) ? int'(rr1) : int'(rr0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-port arbiter and sequencer that shares a single 4-bit `addr_subtr` add/subtract unit between two requesters. Each requester presents operands and an add/sub select over a valid/ready handshake. The block grants one request at a time (round-robin, or fixed priority), latches the operands and drives the shared unit. It then returns the result to the owning requester over a valid/ready response channel. It sits between the datapath clients and the single add/sub instance.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin between ports; 1 = port 0 always wins a simultaneous request.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present on port n.
- `req0_a` / `req1_a`  in  4  operand a.
- `req0_b` / `req1_b`  in  4  operand b.
- `req0_sub` / `req1_sub`  in  1  1 = a−b, 0 = a+b.
- `req0_ready` / `req1_ready`  out  1  request accepted when valid && ready.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for port n.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes result.
- `rsp_result`  out  4  sum/difference; shared by both ports, qualified by `rspN_valid`.
- `rsp_carry`  out  1  carry out; for subtract, 1 = no borrow (a ≥ b unsigned).
- `busy`  out  1  high in EXEC and RESP.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - EXEC: one cycle; shared unit evaluates the latched operands; result and carry are registered.
  - RESP: hold `rspN_valid` for the owner.
- IDLE arbitration:
  - Grant goes to the single valid port.
  - If both ports are valid: with FIXED_PRIO=0 the port not served last wins; with FIXED_PRIO=1 port 0 wins.
  - `reqN_ready` = (state==IDLE) && grant==n && !rst. Combinational from valid; at most one ready high.
- Accept (valid && ready): latch a, b, sub and the owner id; go to EXEC.
- Shared-unit connection: operands from the latched registers; `control_signal` = latched sub.
- EXEC → RESP unconditionally.
- RESP:
  - `rspN_valid` = 1 for the owner only. `rsp_result` and `rsp_carry` are stable until the handshake completes.
  - On `rspN_ready`, go to IDLE and update the last-served pointer to the owner.
  - `rsp_ready` of the non-owner port is ignored.
- Requests are never dropped. A non-granted valid request waits; the requester must hold operands stable until it sees ready.
- Arithmetic is modulo 16 with no saturation. Subtract is two's complement: a + ~b + 1.

## Timing
- Reset values: state IDLE; all `reqN_ready` 0 while rst is high; `rspN_valid` 0; `rsp_result` 0; `rsp_carry` 0; `busy` 0; last-served pointer = port 1, so port 0 wins the first tie.
- Latency: accept at edge T; result registered at T+1; `rspN_valid` high in the cycle after T+1 (visible from T+1 to T+2).
- With `rsp_ready` held high the block is back in IDLE after 3 cycles. Peak throughput is one op per 3 cycles.
- A back-to-back request from the other port is accepted in the first IDLE cycle after the response handshake.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response; state returns to IDLE the next cycle.
- Simultaneous valid on both ports at first IDLE after reset: port 0 is granted.

## Configuration
- `ADDSUB_ARB_OVF_EN` defined:
  - Adds output `rsp_ovf` (1 bit) = signed two's-complement overflow of the executed op.
  - Computed as (a[3] == b'[3]) && (result[3] != a[3]), where b' = b ^ {4{sub}}.
  - Registered with result; reset value 0.
- Not defined: no `rsp_ovf` port and no overflow logic; all other behaviour is identical.

## Test plan
- Reset: rst high 2 cycles with both valids high → both readys 0, both rsp_valid 0, busy 0. Release → port 0 granted first.
- Single add: port 0 sends a=9, b=8, sub=0 → `rsp0_valid` 2 cycles after accept, result=1, carry=1.
- Subtract, no borrow: a=5, b=3 → result=2, carry=1.
- Subtract, borrow: a=3, b=5 → result=14, carry=0.
- Round-robin: both ports hold valid continuously with rsp_ready=1 → grants alternate 0,1,0,1; each op takes 3 cycles. With FIXED_PRIO=1 the grant is port 0 every time.
- Backpressure and reset: hold `rsp1_ready`=0 for 5 cycles → `rsp1_valid` and result stay stable and port 0 stays not-ready. Assert rst in RESP → no response, IDLE next cycle.
- With `ADDSUB_ARB_OVF_EN`: a=7, b=1, add → ovf=1. a=8, b=1, sub → ovf=1. a=2, b=3, add → ovf=0.
